// File: rtl/mibus_arbiter.sv
// Round-robin MIBus arbiter with burst locking: N_REQ masters share one slave.
// Optional per-requester accepted-beat counters when MIBUS_ARB_STATS_EN is defined.
module mibus_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 64,
  parameter int MAX_BURST = 8,
  parameter int STAT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ*WIDTH-1:0]   m_data,
  input  logic [N_REQ-1:0]         m_valid,
  input  logic [N_REQ*4-1:0]       m_adjust_term,
  output logic [N_REQ-1:0]         m_ctrl_flag,
  output logic [WIDTH-1:0]         s_data,
  output logic                     s_valid,
  output logic [3:0]               s_adjust_term,
  input  logic                     s_ctrl_flag,
  output logic [N_REQ-1:0]         grant_oh,
`ifdef MIBUS_ARB_STATS_EN
  output logic [N_REQ*STAT_W-1:0]  stat_beats,
`endif
  output logic                     busy
);

  localparam int IDX_W  = $clog2(N_REQ);
  localparam int BCNT_W = $clog2(MAX_BURST + 1);
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_REQ - 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e              state_q, state_d;
  logic [N_REQ-1:0]    grant_oh_q, grant_oh_d;
  logic [IDX_W-1:0]    g_idx_q, g_idx_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [BCNT_W-1:0]   beat_cnt_q, beat_cnt_d;

  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx;
  logic                xfer;

  assign busy          = (state_q == GRANT);
  assign grant_oh      = grant_oh_q;
  assign s_valid       = busy & m_valid[g_idx_q];
  assign s_data        = busy ? m_data[g_idx_q*WIDTH +: WIDTH] : '0;
  assign s_adjust_term = busy ? m_adjust_term[g_idx_q*4 +: 4] : 4'b0;
  assign m_ctrl_flag   = grant_oh_q & {N_REQ{s_ctrl_flag}};
  assign xfer          = s_valid & s_ctrl_flag;

  // Scan offsets from farthest to nearest so the requester closest to rr_ptr wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    pick_found = |m_valid;
    pick_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      logic [IDX_W:0] cand;
      cand = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(N_REQ)) cand = cand - (IDX_W + 1)'(N_REQ);
      if (m_valid[cand[IDX_W-1:0]]) pick_idx = cand[IDX_W-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_oh_d = grant_oh_q;
    g_idx_d    = g_idx_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = GRANT;
          g_idx_d    = pick_idx;
          grant_oh_d = N_REQ'(1) << pick_idx;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        if (!m_valid[g_idx_q] || (xfer && beat_cnt_q == LAST_BEAT)) begin
          state_d    = IDLE;
          grant_oh_d = '0;
          beat_cnt_d = '0;
          rr_ptr_d   = (g_idx_q == LAST_IDX) ? '0 : g_idx_q + 1'b1;
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q    <= IDLE;
      grant_oh_q <= '0;
      g_idx_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_oh_q <= grant_oh_d;
      g_idx_q    <= g_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef MIBUS_ARB_STATS_EN
  logic [STAT_W-1:0] stat_q [N_REQ];
  logic [STAT_W-1:0] stat_d [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      stat_d[i] = stat_q[i];
      if (xfer && g_idx_q == IDX_W'(i) && stat_q[i] != '1) stat_d[i] = stat_q[i] + 1'b1;
    end
  end

  // NOTE: the counter array is a handful of flops, not a RAM, so it is safe to clear on reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (rst) stat_q[i] <= '0;
      else     stat_q[i] <= stat_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) stat_beats[i*STAT_W +: STAT_W] = stat_q[i];
  end
`endif

endmodule

// File: tb/tb_mibus_arbiter.sv
// Self-checking bench for mibus_arbiter: directed table, hand sequences and a random run
// against a queue-free behavioural model of the round-robin/burst rules.
module tb_mibus_arbiter;
  localparam int N  = 4;
  localparam int W  = 64;
  localparam int MB = 8;
  localparam int SW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N*W-1:0]   m_data;
  logic [N-1:0]     m_valid;
  logic [N*4-1:0]   m_adjust_term;
  logic [N-1:0]     m_ctrl_flag;
  logic [W-1:0]     s_data;
  logic             s_valid;
  logic [3:0]       s_adjust_term;
  logic             s_ctrl_flag;
  logic [N-1:0]     grant_oh;
  logic             busy;
`ifdef MIBUS_ARB_STATS_EN
  logic [N*SW-1:0]  stat_beats;
`endif

  always #5 clk = ~clk;

  mibus_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB), .STAT_W(SW)) dut (
    .clk(clk), .rst(rst), .m_data(m_data), .m_valid(m_valid),
    .m_adjust_term(m_adjust_term), .m_ctrl_flag(m_ctrl_flag), .s_data(s_data),
    .s_valid(s_valid), .s_adjust_term(s_adjust_term), .s_ctrl_flag(s_ctrl_flag),
    .grant_oh(grant_oh),
`ifdef MIBUS_ARB_STATS_EN
    .stat_beats(stat_beats),
`endif
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Model: granted index (-1 when idle), round-robin pointer, beats in current grant.
  int mg = -1;
  int mptr = 0;
  int mbeats = 0;
  int mstat [N];
  bit hold = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [N-1:0] v, input logic c);
    rst = r;
    m_valid = v;
    s_ctrl_flag = c;
    if (!hold) begin
      for (int i = 0; i < N * W / 32; i++) m_data[i*32 +: 32] = $urandom;
      m_adjust_term = N*4'($urandom);
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] eg;
    logic [W-1:0] ed;
    logic [3:0]   ea;
    logic         ev;
    eg = '0; ed = '0; ea = '0; ev = 1'b0;
    if (mg >= 0) begin
      eg[mg] = 1'b1;
      ed = m_data[mg*W +: W];
      ea = m_adjust_term[mg*4 +: 4];
      ev = m_valid[mg];
    end
    check({tag, "_grant"}, 64'(grant_oh), 64'(eg));
    check({tag, "_busy"}, 64'(busy), 64'(mg >= 0));
    check({tag, "_svalid"}, 64'(s_valid), 64'(ev));
    check({tag, "_sdata"}, s_data, ed);
    check({tag, "_sadj"}, 64'(s_adjust_term), 64'(ea));
    check({tag, "_mctrl"}, 64'(m_ctrl_flag), 64'(s_ctrl_flag ? eg : '0));
`ifdef MIBUS_ARB_STATS_EN
    for (int i = 0; i < N; i++) check({tag, "_stat"}, 64'(stat_beats[i*SW +: SW]), 64'(mstat[i]));
`endif
  endtask

  task automatic release_grant();
    mptr = (mg + 1) % N;
    mg = -1;
    mbeats = 0;
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      mg = -1; mptr = 0; mbeats = 0;
      for (int i = 0; i < N; i++) mstat[i] = 0;
    end else if (mg < 0) begin
      for (int k = 0; k < N; k++) begin
        if (mg < 0 && m_valid[(mptr + k) % N]) mg = (mptr + k) % N;
      end
      mbeats = 0;
    end else begin
      if (m_valid[mg] && s_ctrl_flag && mstat[mg] < (1 << SW) - 1) mstat[mg]++;
      if (!m_valid[mg]) release_grant();
      else if (s_ctrl_flag) begin
        mbeats++;
        if (mbeats == MB) release_grant();
      end
    end
    #1;
  endtask

  typedef struct {
    logic         r;
    logic [N-1:0] v;
    logic         c;
    logic [N-1:0] g;
    logic         b;
    logic         sv;
    logic [N-1:0] mc;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int total;
    logic [W-1:0] held;

    rst = 1'b1; m_valid = '0; s_ctrl_flag = 1'b0; m_data = '0; m_adjust_term = '0;
    for (int i = 0; i < N; i++) mstat[i] = 0;

    // Reset with all requesting, single-master burst of 3, then rr pointer moved to 1.
    tbl[0]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000};
    tbl[1]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000};
    tbl[2]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000};
    tbl[3]  = '{1'b0, 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000};
    tbl[4]  = '{1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1, 4'b0001};
    tbl[5]  = '{1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1, 4'b0001};
    tbl[6]  = '{1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1, 4'b0001};
    tbl[7]  = '{1'b0, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b0, 4'b0001};
    tbl[8]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000};
    tbl[9]  = '{1'b0, 4'b0011, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000};
    tbl[10] = '{1'b0, 4'b0011, 1'b1, 4'b0010, 1'b1, 1'b1, 4'b0010};
    tbl[11] = '{1'b0, 4'b0000, 1'b1, 4'b0010, 1'b1, 1'b0, 4'b0010};
    tbl[12] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000};

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].c);
      check("tbl_grant", 64'(grant_oh), 64'(tbl[i].g));
      check("tbl_busy", 64'(busy), 64'(tbl[i].b));
      check("tbl_svalid", 64'(s_valid), 64'(tbl[i].sv));
      check("tbl_mctrl", 64'(m_ctrl_flag), 64'(tbl[i].mc));
      check_model("tbl");
      advance();
    end

    // Fairness: all requesting, grants rotate 0..3 with one bubble every 9 cycles.
    drive(1'b1, '0, 1'b1); advance();
    for (int c = 0; c < 45; c++) begin
      logic [N-1:0] eg;
      drive(1'b0, 4'b1111, 1'b1);
      eg = (c % 9 == 0) ? 4'b0000 : 4'(1 << ((c / 9) % 4));
      check("fair_grant", 64'(grant_oh), 64'(eg));
      check_model("fair");
      advance();
    end

    // Backpressure on req2 after 3 beats: grant and data hold, burst still totals 8 beats.
    drive(1'b1, '0, 1'b1); advance();
    drive(1'b0, 4'b0100, 1'b1); check_model("bp"); advance();
    for (int i = 0; i < 3; i++) begin drive(1'b0, 4'b0100, 1'b1); check_model("bp"); advance(); end
    hold = 1'b1;
    held = m_data[2*W +: W];
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 4'b0100, 1'b0);
      check("bp_stall_grant", 64'(grant_oh), 64'(4'b0100));
      check("bp_stall_data", s_data, held);
      check("bp_stall_mctrl", 64'(m_ctrl_flag), 64'(0));
      check_model("bp");
      advance();
    end
    hold = 1'b0;
    total = 3;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 4'b0100, 1'b1);
      check_model("bp");
      if (grant_oh != 4'b0100) break;
      if (s_valid) total++;
      advance();
    end
    check("bp_total_beats", 64'(total), 64'(MB));
    advance();
    drive(1'b0, 4'b0100, 1'b1);
    check("bp_regrant", 64'(grant_oh), 64'(4'b0100));
    check_model("bp");
    advance();

    // Reset during beat 4 of req1: pointer returns to 0 so req0 wins next.
    drive(1'b1, '0, 1'b1); advance();
    drive(1'b0, 4'b0010, 1'b1); check_model("rmb"); advance();
    for (int i = 0; i < 3; i++) begin drive(1'b0, 4'b0010, 1'b1); check_model("rmb"); advance(); end
    drive(1'b1, 4'b0010, 1'b1); advance();
    drive(1'b0, 4'b0011, 1'b1);
    check("rmb_grant_cleared", 64'(grant_oh), 64'(0));
    check("rmb_busy_cleared", 64'(busy), 64'(0));
    check_model("rmb");
    advance();
    drive(1'b0, 4'b0011, 1'b1);
    check("rmb_req0_first", 64'(grant_oh), 64'(4'b0001));
    check_model("rmb");
    advance();

`ifdef MIBUS_ARB_STATS_EN
    // req2 issues 20 accepted beats; slice saturates at 2^SW-1 when narrower.
    drive(1'b1, '0, 1'b1); advance();
    total = 0;
    for (int i = 0; i < 40 && total < 20; i++) begin
      drive(1'b0, 4'b0100, 1'b1);
      check_model("st");
      if (mg == 2) total++;
      advance();
    end
    drive(1'b0, 4'b0000, 1'b1);
    check("stat_req2", 64'(stat_beats[2*SW +: SW]), 64'((20 > (1 << SW) - 1) ? (1 << SW) - 1 : 20));
    check("stat_req0", 64'(stat_beats[0 +: SW]), 64'(0));
    check("stat_req1", 64'(stat_beats[SW +: SW]), 64'(0));
    check("stat_req3", 64'(stat_beats[3*SW +: SW]), 64'(0));
    advance();
`endif

    // Random traffic against the model.
    drive(1'b1, '0, 1'b1); advance();
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) == 0), N'($urandom), ($urandom_range(0, 3) != 0));
      check_model("rnd");
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
